led_flash_sched: RTL
====================

LED_FLASH_SCHED -- requirements
Module: led_flash_sched

Interface
REQ-001 The block SHALL have parameter ALARM_SECS, default 60, giving the alarm flash duration in seconds (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tick_2hz, input, 1 bit: a one-clk-wide pulse every 0.5 s.
REQ-005 The block SHALL have port alarm_req, input, 1 bit: a one-cycle pulse requesting an alarm flash.
REQ-006 The block SHALL have port alarm_ack, input, 1 bit: a one-cycle pulse that stops the alarm (user key).
REQ-007 The block SHALL have port chime_req, input, 1 bit: a one-cycle pulse at the top of each hour.
REQ-008 The block SHALL have port chime_hour, input, 5 bits: the current hour (0..23), sampled when a chime starts.
REQ-009 The block SHALL have port set_mode, input, 1 bit: a level, high while the user is setting the time.
REQ-010 The block SHALL have port led, output, 8 bits: the LED drive; 1 = lit.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any non-IDLE state.
REQ-012 The block SHALL have port mode, output, 2 bits: the current state code.

Function
REQ-013 The FSM SHALL have states IDLE=0, ALARM=1, CHIME=2, SETBLINK=3; mode SHALL equal the state code.
REQ-014 Priority on a single edge SHALL be: alarm_req > chime_req/pending chime > set_mode.
REQ-015 IDLE: alarm_req -> ALARM; else chime_req or chime_pend -> CHIME; else set_mode=1 -> SETBLINK.
REQ-016 Where alarm_req and alarm_ack coincide outside ALARM, ack SHALL win and the request SHALL be dropped.
REQ-017 On entry to any flashing state, phase SHALL be set to 1 and the half-period counter cleared.
REQ-018 In ALARM, CHIME and SETBLINK, phase SHALL toggle on each tick_2hz.
REQ-019 led SHALL be registered: 8'hFF when in a flashing state with phase=1, otherwise 8'h00; led, state and phase SHALL update on the same edge (one-cycle latency from request).
REQ-020 ALARM SHALL exit after 2*ALARM_SECS tick_2hz pulses, or on the edge alarm_ack is sampled.
REQ-021 CHIME SHALL flash N times, where N = chime_hour mod 12 and 0 maps to 12; N SHALL be latched on entry, and the state SHALL exit after 2*N tick_2hz pulses.
REQ-022 A chime_req during ALARM or SETBLINK SHALL set chime_pend; chime_pend SHALL clear on entry to CHIME.
REQ-023 An alarm_req during CHIME SHALL preempt it; the chime SHALL be abandoned (not re-queued).
REQ-024 An alarm_req during SETBLINK SHALL preempt it.
REQ-025 An alarm_req during ALARM SHALL restart the duration count.
REQ-026 On exit from ALARM/CHIME, the next state SHALL be CHIME if chime_pend, else SETBLINK if set_mode, else IDLE.
REQ-027 SETBLINK SHALL exit to IDLE on the first edge where set_mode=0.
REQ-028 The half-period counter SHALL be 9 bits and SHALL saturate, never wrap; the flash counter SHALL be 5 bits.
REQ-029 A tick_2hz arriving on the entry edge SHALL NOT be counted.

Reset
REQ-030 While rst_n=0, the block SHALL hold state=IDLE, led=8'h00, busy=0, mode=2'b00, phase=0, chime_pend=0 and all counters at 0, regardless of clk.
REQ-031 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL sit in IDLE and act only on new requests.

Structure
REQ-032 Package led_sched_pkg SHALL hold the state enum and codes, LED_ON=8'hFF, LED_OFF=8'h00, and the counter widths.
REQ-033 Sub-module led_phase_gen (inputs clk, rst_n, restart, tick_2hz; output phase) SHALL implement REQ-017/018; the FSM and counters SHALL stay in the top level.

Verification
REQ-034 Reset, then alarm_req with ALARM_SECS=3: led=FF the next cycle and toggles on each tick; after 6 ticks mode=0 and led=00.
REQ-035 chime_req with chime_hour=14: exactly 2 on-pulses, then IDLE; chime_hour=0 and 12: 12 pulses each.
REQ-036 chime_req at tick 2 of ALARM: ALARM completes, then CHIME runs without a gap cycle, mode 1->2.
REQ-037 set_mode=1 then alarm_req, with alarm_ack after 3 ticks: mode 3->1->3; set_mode=0 -> mode=0 next edge.
REQ-038 alarm_req and alarm_ack on the same edge in IDLE: mode stays 0; alarm_req during CHIME: mode 2->1, chime not resumed.
REQ-039 rst_n pulled low mid-CHIME asynchronously: led=00 and busy=0 before the next clk edge; nothing resumes after release.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED flash scheduler.
// State codes double as the externally visible mode value.
package led_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ALARM    = 2'd1,
    S_CHIME    = 2'd2,
    S_SETBLINK = 2'd3
  } state_t;

  localparam logic [7:0] LED_ON  = 8'hFF;
  localparam logic [7:0] LED_OFF = 8'h00;

  localparam int HP_W = 9;  // half-period (tick) counter width
  localparam int FL_W = 5;  // flash count width

  // Number of chime flashes for a 24h hour value: hour mod 12, with 0 shown as 12.
  function automatic logic [FL_W-1:0] chime_count(input logic [4:0] hour);
    logic [4:0] r;
    r = hour % 5'd12;
    return (r == 5'd0) ? 5'd12 : r;
  endfunction

endpackage

// File: rtl/led_phase_gen.sv
// Flash phase generator: forced on at restart, toggled on every 2 Hz tick.
// Latency 1 clk; no backpressure.
module led_phase_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic tick_2hz,
  output logic phase
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else if (restart) begin
      phase <= 1'b1;
    end else if (tick_2hz) begin
      phase <= ~phase;
    end
  end

endmodule

// File: rtl/led_flash_sched.sv
// Arbitrates alarm, hourly chime and time-set blinking onto one LED bank.
// led/mode update one clk after the request edge; requests are pulses, never stalled.
module led_flash_sched
  import led_sched_pkg::*;
#(
  parameter int ALARM_SECS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_2hz,
  input  logic       alarm_req,
  input  logic       alarm_ack,
  input  logic       chime_req,
  input  logic [4:0] chime_hour,
  input  logic       set_mode,
  output logic [7:0] led,
  output logic       busy,
  output logic [1:0] mode
);

  localparam logic [HP_W-1:0] ALARM_HP = HP_W'(2 * ALARM_SECS);

  state_t            state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [FL_W-1:0]   fl_q, fl_d;
  logic              pend_q, pend_d;
  logic [7:0]        led_q;
  logic              phase, phase_d;
  logic              restart, rearm;
  logic              alarm_go, pend_now;
  logic [HP_W-1:0]   hp_inc, chime_hp;
  state_t            exit_to;

  // A coincident ack cancels a fresh alarm request.
  assign alarm_go = alarm_req & ~alarm_ack;
  assign hp_inc   = (hp_q == {HP_W{1'b1}}) ? hp_q : hp_q + 1'b1;
  assign chime_hp = {{(HP_W-FL_W-1){1'b0}}, fl_q, 1'b0};
  assign pend_now = pend_q | (chime_req & ((state_q == S_ALARM) | (state_q == S_SETBLINK)));
  assign exit_to  = pend_now ? S_CHIME : (set_mode ? S_SETBLINK : S_IDLE);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    fl_d    = fl_q;
    pend_d  = pend_now;
    rearm   = 1'b0;
    restart = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (alarm_go)                 state_d = S_ALARM;
        else if (chime_req || pend_q) state_d = S_CHIME;
        else if (set_mode)            state_d = S_SETBLINK;
      end
      S_ALARM: begin
        if (alarm_ack)      state_d = exit_to;
        else if (alarm_req) rearm   = 1'b1;
        else if (tick_2hz) begin
          if (hp_inc >= ALARM_HP) state_d = exit_to;
          else                    hp_d    = hp_inc;
        end
      end
      S_CHIME: begin
        if (alarm_go) state_d = S_ALARM;
        else if (tick_2hz) begin
          if (hp_inc >= chime_hp) state_d = exit_to;
          else                    hp_d    = hp_inc;
        end
      end
      S_SETBLINK: begin
        if (alarm_go)       state_d = S_ALARM;
        else if (!set_mode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Entry edge: the tick on this edge is not counted.
    restart = (state_d != S_IDLE) && ((state_d != state_q) || rearm);
    if (restart || (state_d == S_IDLE)) hp_d = '0;
    if (restart && (state_d == S_CHIME)) begin
      fl_d   = chime_count(chime_hour);
      pend_d = 1'b0;
    end
  end

  // Mirrors the phase register's next value so led lands on the same edge.
  assign phase_d = restart ? 1'b1 : (tick_2hz ? ~phase : phase);

  led_phase_gen u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .tick_2hz (tick_2hz),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hp_q    <= '0;
      fl_q    <= '0;
      pend_q  <= 1'b0;
      led_q   <= LED_OFF;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      fl_q    <= fl_d;
      pend_q  <= pend_d;
      led_q   <= ((state_d != S_IDLE) && phase_d) ? LED_ON : LED_OFF;
    end
  end

  assign led  = led_q;
  assign busy = (state_q != S_IDLE);
  assign mode = state_q;

endmodule
